bcd_digit_serializer: RTL and testbench
=======================================

Name: bcd_digit_serializer

Overview:
- Upstream feeder for the BCD-to-excess-3 code converter.
- Accepts one packed multi-digit BCD word per valid/ready handshake and emits its digits one per cycle on a 4-bit digit stream, with first/last markers.
- Flags non-BCD nibbles (values 10..15) so downstream excess-3 logic never silently converts don't-care codes.
- Sits between a parallel BCD source (register file or counter) and the per-digit converter.

Parameters:
- DIGITS, 4, number of BCD digits per input word (legal range 2..8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a word.
- in_ready  output  1  serializer can accept a word this cycle.
- in_bcd  input  4*DIGITS  packed BCD word; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- out_valid  output  1  out_digit is valid.
- out_ready  input  1  consumer accepts the digit this cycle.
- out_digit  output  4  current BCD digit.
- out_first  output  1  current digit is the first of its word.
- out_last  output  1  current digit is the last of its word.
- out_err  output  1  current digit is greater than 9.
- word_err  output  1  sticky per word: any digit of the word in flight is greater than 9; cleared when the next word is accepted.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid = 0, out_first = 0, out_last = 0, out_err = 0, word_err = 0, out_digit = 0.
  - in_ready = 1, state = IDLE, digit index = 0.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On an input transfer, capture in_bcd into the shift register, set index = 0, compute word_err = OR over all digits of (digit > 9), and go to SEND.
  - SEND: out_valid = 1.
    - out_digit = digit at index (MSD first by default).
    - out_first = (index == 0); out_last = (index == DIGITS-1); out_err = (out_digit > 9).
    - On an output transfer with !out_last: increment index and stay in SEND.
    - On an output transfer with out_last: if in_valid, capture the new word and restart at index 0 (back-to-back, no bubble); otherwise go to IDLE.
- in_ready in SEND = out_valid && out_ready && out_last. This combinational path from out_ready to in_ready is intended.
- Latency: first digit is valid in the cycle after the input transfer. Throughput is DIGITS cycles per word when out_ready is held high.
- Back-pressure: while out_ready = 0, out_digit, out_first, out_last, out_err and word_err hold stable; index does not advance.
- Index width is ceil(log2(DIGITS)). The index never exceeds DIGITS-1; no wrap past the last digit.
- Invalid digits are passed through unchanged. They are flagged only, never clamped or dropped.
- in_bcd is ignored whenever no input transfer occurs.
- Reset mid-word: the word in flight is discarded, with no partial last beat. Outputs take their reset values on the next edge.
- DIGITS = 1 is not supported (elaboration-time check).

Optional Feature:
- Macro: BCD_SER_LSD_FIRST_EN.
- Defined: digits are emitted least-significant first (digit 0 first, digit DIGITS-1 carries out_last). Suits ripple-carry arithmetic downstream.
- Undefined: digits are emitted most-significant first (digit DIGITS-1 first). Suits display and print paths.
- Handshake, latency and flags are identical in both builds.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W = 4 and BCD_MAX = 4'd9.
  - State enum {IDLE, SEND}.
  - Function is_bcd(nibble) returning nibble <= 9.
  - Reused by the converter's checker and by the bench.
- One natural sub-module: bcd_digit_check, a combinational nibble-valid/err flag generator instantiated per output digit and reduced for word_err.
- Shift register, index counter and FSM stay in the top module.

Test Plan:
- Single word, out_ready = 1, in_bcd = 16'h1928, MSD build:
  - Expected digits 1, 9, 2, 8 on 4 consecutive cycles after accept.
  - out_first on digit 1, out_last on digit 8, word_err = 0; in_ready returns to 1.
- Back-to-back: words 16'h0042 then 16'h9999, in_valid held high:
  - Digits 0, 0, 4, 2, 9, 9, 9, 9 with no idle cycle between words.
  - Second accept coincides with the out_last transfer of the first word.
- Back-pressure: word 16'h5071, out_ready toggled 1, 0, 0, 1, 1, 0, 1:
  - Each digit is held stable while out_ready = 0.
  - Exactly 4 transfers occur, in order 5, 0, 7, 1.
- Invalid digit: in_bcd = 16'h3A07:
  - word_err = 1 from the first out_valid cycle onward.
  - out_err = 1 only on the digit 4'hA; the digit 4'hA is still emitted.
- Reset mid-word: assert rst after 2 digits of 16'h1234:
  - Next cycle: out_valid = 0, in_ready = 1.
  - A subsequent word 16'h5678 emits 5, 6, 7, 8 with out_first on 5.
- LSD build (BCD_SER_LSD_FIRST_EN defined): in_bcd = 16'h1928 emits 8, 2, 9, 1, with out_last on 1.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD widths, limits, FSM states and digit check
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_serializer_if.sv
// rtl/bcd_digit_serializer_if.sv - word input and digit output streams of the serializer
interface bcd_digit_serializer_if #(
    parameter int DIGITS = 4
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_digit;
    logic                  out_first;
    logic                  out_last;
    logic                  out_err;
    logic                  word_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_digit, out_first, out_last, out_err, word_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_digit, out_first, out_last, out_err, word_err
    );

endinterface

// File: rtl/bcd_digit_check.sv
// rtl/bcd_digit_check.sv - flags a nibble that is not a legal BCD digit
module bcd_digit_check
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    output logic               err
);

    assign err = !is_bcd(nibble);

endmodule

// File: rtl/bcd_digit_serializer.sv
// rtl/bcd_digit_serializer.sv - packed BCD word to one-digit-per-beat stream, MSD first
// unless BCD_SER_LSD_FIRST_EN is defined (then LSD first).
module bcd_digit_serializer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_digit_serializer_if.slave   bus
);

    localparam int WORD_W = DIGIT_W * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_digit_serializer: DIGITS must be within 2..8");
    end

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                word_err_q, word_err_d;

    logic [DIGITS-1:0]   in_err;
    logic [DIGIT_W-1:0]  head;
    logic                head_err;
    logic                is_last;
    logic                capture;

    for (genvar k = 0; k < DIGITS; k++) begin : g_in_chk
        bcd_digit_check u_in_chk (
            .nibble (bus.in_bcd[DIGIT_W*k +: DIGIT_W]),
            .err    (in_err[k])
        );
    end

    // The digit on the wire always sits at the shift-out end of the register.
`ifdef BCD_SER_LSD_FIRST_EN
    assign head = shreg_q[DIGIT_W-1:0];
`else
    assign head = shreg_q[WORD_W-1 -: DIGIT_W];
`endif

    bcd_digit_check u_out_chk (
        .nibble (head),
        .err    (head_err)
    );

    assign is_last       = (idx_q == LAST_IDX);
    assign capture       = bus.in_valid && bus.in_ready;
    assign bus.out_digit = head;
    assign bus.word_err  = word_err_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shreg_d       = shreg_q;
        word_err_d    = word_err_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_err   = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
            end
            SEND: begin
                bus.out_valid = 1'b1;
                bus.out_first = (idx_q == '0);
                bus.out_last  = is_last;
                bus.out_err   = head_err;
                bus.in_ready  = bus.out_ready && is_last;
                if (bus.out_ready) begin
                    // Shifting on the last beat too leaves zeros behind in IDLE.
`ifdef BCD_SER_LSD_FIRST_EN
                    shreg_d = shreg_q >> DIGIT_W;
`else
                    shreg_d = shreg_q << DIGIT_W;
`endif
                    if (!is_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            shreg_d    = bus.in_bcd;
            idx_d      = '0;
            word_err_d = |in_err;
            state_d    = SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            shreg_q    <= '0;
            word_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            word_err_q <= word_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// tb/tb_bcd_digit_serializer.sv - scoreboard bench for bcd_digit_serializer (either digit order)
module tb_bcd_digit_serializer;
    import bcd_pkg::*;

    localparam int DIGITS = 4;

    typedef struct packed {
        logic [3:0] digit;
        logic       first;
        logic       last;
        logic       err;
        logic       werr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_digit_serializer_if #(.DIGITS(DIGITS)) bus ();

    bcd_digit_serializer #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_xfer = 0;
    bit         acc;
    int         cyc;
    bit         hold_chk = 1'b0;
    exp_t       held;
    logic [3:0] held_digit;
    int         pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference order: MSD first unless the LSD build is selected.
    task automatic push_word(input logic [4*DIGITS-1:0] w);
        exp_t e;
        logic werr;
        int   pos;
        werr = 1'b0;
        for (int k = 0; k < DIGITS; k++) werr |= !is_bcd(w[4*k +: 4]);
        for (int k = 0; k < DIGITS; k++) begin
`ifdef BCD_SER_LSD_FIRST_EN
            pos = k;
`else
            pos = DIGITS - 1 - k;
`endif
            e.digit = w[4*pos +: 4];
            e.first = (k == 0);
            e.last  = (k == DIGITS - 1);
            e.err   = !is_bcd(e.digit);
            e.werr  = werr;
            sb_q.push_back(e);
        end
    endtask

    task automatic tick(output bit accepted);
        exp_t e;
        @(negedge clk);
        if (hold_chk) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_digit", bus.out_digit, held_digit);
            chk("hold_first", bus.out_first, held.first);
            chk("hold_last",  bus.out_last,  held.last);
            chk("hold_err",   bus.out_err,   held.err);
            chk("hold_werr",  bus.word_err,  held.werr);
        end
        hold_chk = !rst && bus.out_valid && !bus.out_ready;
        held_digit = bus.out_digit;
        held.first = bus.out_first;
        held.last  = bus.out_last;
        held.err   = bus.out_err;
        held.werr  = bus.word_err;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                chk("unexpected_digit", 32'(bus.out_digit), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("digit", bus.out_digit, e.digit);
                chk("first", bus.out_first, e.first);
                chk("last",  bus.out_last,  e.last);
                chk("err",   bus.out_err,   e.err);
                chk("werr",  bus.word_err,  e.werr);
            end
        end
        accepted = !rst && bus.in_valid && bus.in_ready;
        if (accepted) push_word(bus.in_bcd);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc, output int cycles);
        bit a;
        cycles = 0;
        while (sb_q.size() > 0 && cycles < max_cyc) begin
            tick(a);
            cycles++;
        end
        chk("drain_left", sb_q.size(), 0);
    endtask

    task automatic check_idle(input string tag, input logic werr);
        @(negedge clk);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_in_ready"},  bus.in_ready,  1'b1);
        chk({tag, "_word_err"},  bus.word_err,  werr);
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [4*DIGITS-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_bcd   = w;
        tick(acc);
        chk("accept", acc, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_bcd   = 16'(($urandom));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_first", bus.out_first, 1'b0);
        chk("rst_out_last",  bus.out_last,  1'b0);
        chk("rst_out_err",   bus.out_err,   1'b0);
        chk("rst_word_err",  bus.word_err,  1'b0);
        chk("rst_out_digit", bus.out_digit, 4'd0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word at full throughput.
        bus.out_ready = 1'b1;
        send_one(16'h1928);
        drain(20, cyc);
        chk("single_cycles", cyc, DIGITS);
        check_idle("single_idle", 1'b0);

        // Back-to-back words with in_valid held high.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h0042;
        tick(acc);
        chk("b2b_accept0", acc, 1'b1);
        bus.in_bcd = 16'h9999;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
            tick(acc);
            cyc++;
        end
        chk("b2b_accept1_cycle", cyc, DIGITS);
        bus.in_valid = 1'b0;
        drain(20, cyc);
        chk("b2b_drain_cycles", cyc, DIGITS);
        check_idle("b2b_idle", 1'b0);

        // Back-pressure pattern.
        send_one(16'h5071);
        n_xfer = 0;
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i][0];
            tick(acc);
        end
        bus.out_ready = 1'b1;
        chk("bp_xfers", n_xfer, 4);
        chk("bp_left", sb_q.size(), 0);
        check_idle("bp_idle", 1'b0);

        // Invalid digit is flagged and passed through.
        send_one(16'h3A07);
        drain(20, cyc);
        check_idle("inv_idle", 1'b1);

        // All-invalid boundary word.
        send_one(16'hFACB);
        drain(20, cyc);

        // Reset with a word in flight.
        send_one(16'h1234);
        tick(acc);
        tick(acc);
        chk("rst_mid_left", sb_q.size(), 2);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        sb_q.delete();
        check_idle("rst_mid", 1'b0);
        send_one(16'h5678);
        drain(20, cyc);
        chk("after_rst_cycles", cyc, DIGITS);
        check_idle("final_idle", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
